// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundle (instruction memory, execute redirect, decode handshake)
// master (fetch side) drives imem_req/imem_addr and instruction/pc/inst_valid;
// slave (memory/decode/execute side) drives imem_ready/imem_rvalid/imem_rdata, redirect/redirect_pc, stall.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        inst_valid;
  modport master (
    output imem_req, imem_addr, instruction, pc, inst_valid,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
  modport slave (
    input  imem_req, imem_addr, instruction, pc, inst_valid,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch.sv
// fetch: single-outstanding instruction fetch stage with redirect and decode valid/stall handshake
// Ports: clk, rst (async, active-high); bus (fetch_if.master) carries the imem request/response,
// the execute redirect and the decode handshake; fetch_misaligned is a sticky flag present only
// when FETCH_ALIGN_CHECK_EN is defined (misaligned redirect locks the stage until rst).
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic    fetch_misaligned
`endif
);
  localparam logic [1:0] REQ   = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [1:0] ERR   = 2'd3;
`endif
  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic        started_q;
  logic [31:0] instruction_q, instruction_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        accept;
  logic        take_redirect;
  logic [31:0] target;
  assign accept = bus.imem_req && bus.imem_ready;
  assign target = {bus.redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic bad_target;
  assign bad_target       = |bus.redirect_pc[1:0];
  assign take_redirect    = bus.redirect && state_q != ERR;
  assign fetch_misaligned = misaligned_q;
`else
  logic unused_lsb;
  assign unused_lsb    = ^bus.redirect_pc[1:0];
  assign take_redirect = bus.redirect;
`endif
  // started_q holds imem_req low for the first cycle after reset release
  assign bus.imem_req    = started_q && state_q == REQ;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instruction = instruction_q;
  assign bus.pc          = pc_q;
  assign bus.inst_valid  = inst_valid_q;
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    kill_d        = kill_q;
    instruction_d = instruction_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned_d  = misaligned_q;
`endif
    if (take_redirect) begin
      fetch_pc_d    = target;
      inst_valid_d  = 1'b0;
      instruction_d = NOP_INST;
      // a request already in flight (or accepted now) must have its response discarded
      state_d = state_q == REQ  ? (accept ? WAIT : REQ) :
                state_q == WAIT ? (bus.imem_rvalid ? REQ : WAIT) : REQ;
      kill_d  = state_q == REQ  ? accept :
                state_q == WAIT ? !bus.imem_rvalid : 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bad_target) begin
        state_d      = ERR;
        kill_d       = 1'b0;
        misaligned_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        REQ: state_d = accept ? WAIT : REQ;
        WAIT: begin
          if (bus.imem_rvalid && kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (bus.imem_rvalid) begin
            instruction_d = bus.imem_rdata;
            pc_d          = fetch_pc_q;
            inst_valid_d  = 1'b1;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            state_d       = VALID;
          end
        end
        VALID: begin
          if (!bus.stall) begin
            inst_valid_d  = 1'b0;
            instruction_d = NOP_INST;
            state_d       = REQ;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ERR: state_d = ERR;
`endif
        default: state_d = REQ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= REQ;
      fetch_pc_q    <= RESET_PC;
      kill_q        <= 1'b0;
      started_q     <= 1'b0;
      instruction_q <= NOP_INST;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      kill_q        <= kill_d;
      started_q     <= 1'b1;
      instruction_q <= instruction_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
    end
  end
`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned_q <= 1'b0;
    else     misaligned_q <= misaligned_d;
  end
`endif
endmodule
